// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: emits W0..W63 on out0, one registered word per cycle, after a run/delay0 start.
// Define SHA256_SCHED_LOOP_EN to stream consecutive blocks back to back with a one-cycle done pulse per block.

module sha256_msg_sched #(
  parameter int DELAY_W = 10,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic              done,
  input  logic [7:0]        delay0
);

  logic [DELAY_W-1:0] delay;
  logic [6:0]         step;
  logic               active;
  logic [DATA_W-1:0]  win [16];
  logic [DATA_W-1:0]  w_next;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win[k] holds W_{t-1-k} at step t, so the taps below are W_{t-2}, W_{t-7}, W_{t-15}, W_{t-16}.
  always_comb begin
    w_next = in0;
    if (step >= 7'd16) begin
      w_next = sig1(win[1]) + win[6] + sig0(win[14]) + win[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      delay  <= '0;
      step   <= '0;
      active <= 1'b0;
      out0   <= '0;
      done   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (run) begin
      delay  <= DELAY_W'(delay0);
      step   <= '0;
      active <= 1'b1;
      done   <= 1'b0;
    end else if (active) begin
      if (delay != '0) begin
        delay <= delay - DELAY_W'(1);
      end else begin
        out0   <= w_next;
        win[0] <= w_next;
        for (int i = 1; i < 16; i++) begin
          win[i] <= win[i-1];
        end
        if (step == 7'd63) begin
          done <= 1'b1;
`ifdef SHA256_SCHED_LOOP_EN
          step <= '0;
`else
          step   <= 7'd64;
          active <= 1'b0;
`endif
        end else begin
          step <= step + 7'd1;
`ifdef SHA256_SCHED_LOOP_EN
          done <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: randomized blocks checked against an array-based schedule model.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] in0;
  logic [31:0] out0;
  logic        done;
  logic [7:0]  delay0;

  int checks = 0;
  int errors = 0;

  logic [31:0] blk     [32];
  logic [31:0] exp_w   [128];
  logic [31:0] obs_out [200];
  logic        obs_done[200];

  always #5 clk = ~clk;

  sha256_msg_sched #(.DELAY_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .in0(in0),
    .out0(out0), .done(done), .delay0(delay0)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook SHA-256 expansion for the two blocks held in blk[0..15] and blk[16..31].
  task automatic model();
    for (int b = 0; b < 2; b++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) exp_w[b*64+t] = blk[b*16+t];
        else exp_w[b*64+t] = s1(exp_w[b*64+t-2]) + exp_w[b*64+t-7]
                             + s0(exp_w[b*64+t-15]) + exp_w[b*64+t-16];
      end
    end
  endtask

  task automatic random_blocks();
    for (int i = 0; i < 32; i++) blk[i] = $urandom;
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic [31:0] w);
    run = r; delay0 = d; in0 = w;
    @(posedge clk); #1;
  endtask

  // Pulses run in the current cycle (c=0) and records out0/done seen in cycles R+0..R+n.
  task automatic run_block(input int d, input int n);
    for (int c = 0; c <= n; c++) begin
      int ti;
      logic [31:0] w;
      ti = c - 1 - d;
      w = $urandom;
      if (ti >= 0 && ti < 128 && (ti % 64) < 16) w = blk[(ti/64)*16 + (ti%64)];
      obs_out[c]  = out0;
      obs_done[c] = done;
      if (c == 0) drive(1'b1, 8'(d), w);
      else drive(1'b0, 8'($urandom), w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; in0 = $urandom; delay0 = 8'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out0 !== 32'h0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d out0=%h done=%b required out0=0 done=0", i, out0, done);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'($urandom), $urandom);
      checks++;
      if (out0 !== 32'h0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d out0=%h done=%b required out0=0 done=0", i, out0, done);
      end
    end
  endtask

  task automatic test_abc();
    logic [31:0] known [4];
    known[0] = 32'h61626380; known[1] = 32'h000F0000;
    known[2] = 32'h7DA86405; known[3] = 32'h600003C6;
    random_blocks();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    model();
    run_block(0, 70);
    checks++;
    if (obs_out[1] !== 32'h0) begin
      errors++;
      $display("FAIL abc_pre out0=%h required 00000000", obs_out[1]);
    end
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (obs_out[t+2] !== exp_w[t]) begin
        errors++;
        $display("FAIL abc_w%0d out0=%h required %h", t, obs_out[t+2], exp_w[t]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_out[18+k] !== known[k]) begin
        errors++;
        $display("FAIL abc_known_w%0d out0=%h required %h", 16+k, obs_out[18+k], known[k]);
      end
    end
    for (int c = 1; c <= 64; c++) begin
      checks++;
      if (obs_done[c] !== 1'b0) begin
        errors++;
        $display("FAIL abc_done_early R+%0d done=%b required 0", c, obs_done[c]);
      end
    end
`ifdef SHA256_SCHED_LOOP_EN
    checks++;
    if (obs_done[65] !== 1'b1) begin
      errors++;
      $display("FAIL abc_done_pulse done=%b required 1", obs_done[65]);
    end
`else
    for (int c = 65; c <= 70; c++) begin
      checks++;
      if (obs_done[c] !== 1'b1 || obs_out[c] !== exp_w[63]) begin
        errors++;
        $display("FAIL abc_hold R+%0d done=%b out0=%h required done=1 out0=%h",
                 c, obs_done[c], obs_out[c], exp_w[63]);
      end
    end
`endif
  endtask

  task automatic test_delay();
`ifndef SHA256_SCHED_LOOP_EN
    logic [31:0] prev;
    prev = exp_w[63];
`endif
    run_block(5, 72);
`ifndef SHA256_SCHED_LOOP_EN
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (obs_out[c] !== prev) begin
        errors++;
        $display("FAIL delay_quiet R+%0d out0=%h required %h", c, obs_out[c], prev);
      end
    end
`endif
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (obs_out[t+7] !== exp_w[t]) begin
        errors++;
        $display("FAIL delay_w%0d out0=%h required %h", t, obs_out[t+7], exp_w[t]);
      end
    end
    for (int c = 1; c <= 70; c++) begin
      checks++;
      if (obs_done[c] !== (c == 70)) begin
        errors++;
        $display("FAIL delay_done R+%0d done=%b required %b", c, obs_done[c], c == 70);
      end
    end
  endtask

  task automatic test_restart();
    random_blocks();
    model();
    run_block(0, 30);
    for (int t = 0; t <= 28; t++) begin
      checks++;
      if (obs_out[t+2] !== exp_w[t]) begin
        errors++;
        $display("FAIL restart_a_w%0d out0=%h required %h", t, obs_out[t+2], exp_w[t]);
      end
    end
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    model();
    run_block(0, 66);
    for (int c = 0; c <= 64; c++) begin
      checks++;
      if (obs_done[c] !== 1'b0) begin
        errors++;
        $display("FAIL restart_done R+%0d done=%b required 0", c, obs_done[c]);
      end
    end
    for (int t = 0; t < 64; t++) begin
      checks++;
      if (obs_out[t+2] !== exp_w[t]) begin
        errors++;
        $display("FAIL restart_b_w%0d out0=%h required %h", t, obs_out[t+2], exp_w[t]);
      end
    end
    checks++;
    if (obs_out[18] !== 32'h203FFFFC) begin
      errors++;
      $display("FAIL restart_w16 out0=%h required 203ffffc", obs_out[18]);
    end
    checks++;
    if (obs_done[65] !== 1'b1) begin
      errors++;
      $display("FAIL restart_done_end done=%b required 1", obs_done[65]);
    end
  endtask

  task automatic test_back_to_back();
`ifdef SHA256_SCHED_LOOP_EN
    random_blocks();
    model();
    run_block(0, 131);
    for (int t = 0; t < 128; t++) begin
      checks++;
      if (obs_out[t+2] !== exp_w[t]) begin
        errors++;
        $display("FAIL loop_w%0d out0=%h required %h", t, obs_out[t+2], exp_w[t]);
      end
    end
    for (int c = 1; c <= 131; c++) begin
      checks++;
      if (obs_done[c] !== (c == 65 || c == 129)) begin
        errors++;
        $display("FAIL loop_done R+%0d done=%b required %b", c, obs_done[c], c == 65 || c == 129);
      end
    end
`else
    for (int n = 0; n < 2; n++) begin
      random_blocks();
      model();
      run_block(0, 69);
      checks++;
      if (obs_done[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_done_clear done=%b required 0", n, obs_done[1]);
      end
      for (int t = 0; t < 64; t++) begin
        checks++;
        if (obs_out[t+2] !== exp_w[t]) begin
          errors++;
          $display("FAIL b2b%0d_w%0d out0=%h required %h", n, t, obs_out[t+2], exp_w[t]);
        end
      end
      for (int c = 65; c <= 69; c++) begin
        checks++;
        if (obs_done[c] !== 1'b1) begin
          errors++;
          $display("FAIL b2b%0d_done R+%0d done=%b required 1", n, c, obs_done[c]);
        end
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    random_blocks();
    model();
    run_block(0, 20);
    rst = 1'b1;
    drive(1'b1, 8'd0, $urandom);
    rst = 1'b0;
    checks++;
    if (out0 !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid out0=%h done=%b required out0=0 done=0", out0, done);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'($urandom), $urandom);
      checks++;
      if (out0 !== 32'h0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle cyc%0d out0=%h done=%b required 0", i, out0, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_delay();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
